// File: rtl/axi_bram_target.sv
// AXI4 slave backed by a single-port block RAM; one transaction in flight,
// round-robin between write and read requests, INCR bursts up to 256 beats.
module axi_bram_target #(
  parameter int WIDTH = 32,
  parameter int MASKS = WIDTH / 8,
  parameter int ADDRS = 27,
  parameter int REQID = 4,
  parameter int RBITS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             awvalid_i,
  output logic             awready_o,
  input  logic [1:0]       awburst_i,
  input  logic [7:0]       awlen_i,
  input  logic [REQID-1:0] awid_i,
  input  logic [ADDRS-1:0] awaddr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic             wlast_i,
  input  logic [MASKS-1:0] wstrb_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             bvalid_o,
  input  logic             bready_i,
  output logic [REQID-1:0] bid_o,
  output logic [1:0]       bresp_o,
  input  logic             arvalid_i,
  output logic             arready_o,
  input  logic [1:0]       arburst_i,
  input  logic [7:0]       arlen_i,
  input  logic [REQID-1:0] arid_i,
  input  logic [ADDRS-1:0] araddr_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic             rlast_o,
  output logic [REQID-1:0] rid_o,
  output logic [1:0]       rresp_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int BSB = $clog2(MASKS);
  localparam int HIB = RBITS + BSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, WDAT, BRSP, RDAT} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;   // 0: write wins a tie, 1: read wins
  logic [RBITS-1:0] idx_q, idx_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [REQID-1:0] bid_q, bid_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [REQID-1:0] rid_q, rid_d;
  logic [WIDTH-1:0] rdata_q;

  logic [WIDTH-1:0] mem [0:(1<<RBITS)-1];

  logic             aw_grant, ar_grant;
  logic [ADDRS-1:0] a_addr;
  logic [7:0]       a_len;
  logic [1:0]       a_burst;
  logic [RBITS-1:0] a_idx;
  logic [RBITS:0]   a_end;
  logic             a_hi_err;
  logic             a_err;
  logic             unused_addr_bits;

  logic             w_fire, w_last, w_len_hit, mem_we;
  logic             r_fire, rd_en, rd_zero;
  logic [RBITS-1:0] rd_idx;

  always_comb begin
    aw_grant = 1'b0;
    ar_grant = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (awvalid_i && (!arvalid_i || !prio_q)) aw_grant = 1'b1;
      else if (arvalid_i)                       ar_grant = 1'b1;
    end
  end

  // Both address channels share one capture/check path; only one is granted.
  assign a_addr  = aw_grant ? awaddr_i  : araddr_i;
  assign a_len   = aw_grant ? awlen_i   : arlen_i;
  assign a_burst = aw_grant ? awburst_i : arburst_i;
  assign a_idx   = a_addr[HIB-1:BSB];
  assign a_end   = {1'b0, a_idx} + {{(RBITS-7){1'b0}}, a_len};
  assign unused_addr_bits = ^a_addr[BSB-1:0];

  if (ADDRS > HIB) begin : g_hi_bits
    assign a_hi_err = |a_addr[ADDRS-1:HIB];
  end else begin : g_no_hi_bits
    assign a_hi_err = 1'b0;
  end

  assign a_err = (a_burst != BURST_INCR) || a_hi_err || a_end[RBITS];

  assign w_fire    = (state_q == WDAT) && wvalid_i;
  assign w_len_hit = (cnt_q == len_q);
  assign w_last    = wlast_i || w_len_hit;
  assign mem_we    = w_fire && !err_q;

  // Reads are issued one beat ahead so rdata_q already holds the next beat.
  assign r_fire  = rvalid_q && rready_i;
  assign rd_en   = ar_grant || (r_fire && !rlast_q);
  assign rd_idx  = ar_grant ? a_idx : idx_q;
  assign rd_zero = ar_grant ? a_err : err_q;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: begin
        if (aw_grant) begin
          state_d = WDAT;
          prio_d  = 1'b1;
          idx_d   = a_idx;
          len_d   = a_len;
          cnt_d   = 8'd0;
          err_d   = a_err;
          bid_d   = awid_i;
        end else if (ar_grant) begin
          state_d  = RDAT;
          prio_d   = 1'b0;
          idx_d    = a_idx + RBITS'(1);
          len_d    = a_len;
          cnt_d    = 8'd0;
          err_d    = a_err;
          rid_d    = arid_i;
          rvalid_d = 1'b1;
          rlast_d  = (a_len == 8'd0);
          rresp_d  = a_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      WDAT: begin
        if (wvalid_i) begin
          idx_d = idx_q + RBITS'(1);
          cnt_d = cnt_q + 8'd1;
          if (w_last) begin
            state_d  = BRSP;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || (wlast_i != w_len_hit)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      BRSP: begin
        if (bready_i) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RDAT: begin
        if (rready_i) begin
          if (rlast_q) begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            idx_d   = idx_q + RBITS'(1);
            cnt_d   = cnt_q + 8'd1;
            rlast_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bid_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
      rid_q    <= rid_d;
    end
  end

  always_ff @(posedge clock) begin
    idx_q <= idx_d;
    len_q <= len_d;
    cnt_q <= cnt_d;
    err_q <= err_d;
  end

  // Block RAM: byte-masked write port, registered read with enable and a
  // synchronous clear used for error bursts.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < MASKS; b++) begin
        if (wstrb_i[b]) mem[idx_q][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (rd_en) begin
      if (rd_zero) rdata_q <= '0;
      else         rdata_q <= mem[rd_idx];
    end
  end

  assign awready_o = aw_grant;
  assign arready_o = ar_grant;
  assign wready_o  = (state_q == WDAT);
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign bid_o     = bid_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rresp_o   = rresp_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_axi_bram_target.sv
// Scoreboard bench for axi_bram_target: directed AXI scenarios followed by
// random traffic, checked against a word-array memory model.
`timescale 1ns/1ps
module tb_axi_bram_target;

  localparam int DEPTH = 1024;

  logic        clock, reset;
  logic        awvalid_i, awready_o;
  logic [1:0]  awburst_i;
  logic [7:0]  awlen_i;
  logic [3:0]  awid_i;
  logic [26:0] awaddr_i;
  logic        wvalid_i, wready_o, wlast_i;
  logic [3:0]  wstrb_i;
  logic [31:0] wdata_i;
  logic        bvalid_o, bready_i;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        arvalid_i, arready_o;
  logic [1:0]  arburst_i;
  logic [7:0]  arlen_i;
  logic [3:0]  arid_i;
  logic [26:0] araddr_i;
  logic        rvalid_o, rready_i, rlast_o;
  logic [3:0]  rid_o;
  logic [1:0]  rresp_o;
  logic [31:0] rdata_o;

  axi_bram_target dut (
    .clock(clock), .reset(reset),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awburst_i(awburst_i),
    .awlen_i(awlen_i), .awid_i(awid_i), .awaddr_i(awaddr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wlast_i(wlast_i),
    .wstrb_i(wstrb_i), .wdata_i(wdata_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .arburst_i(arburst_i),
    .arlen_i(arlen_i), .arid_i(arid_i), .araddr_i(araddr_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rlast_o(rlast_o),
    .rid_o(rid_o), .rresp_o(rresp_o), .rdata_o(rdata_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; logic last;
                   logic [31:0] data; logic [31:0] mask; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];

  logic [31:0] model_mem   [DEPTH];
  logic [3:0]  model_known [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  int n_cmp = 0;
  int n_fail = 0;
  int aw_waited, ar_waited;
  logic aw_snap_ar, aw_snap_w, ar_snap_aw;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic abort(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting on the DUT", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "bench aborted");
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return awready_o;
      1: return arready_o;
      2: return wready_o;
      3: return bvalid_o;
      default: return rvalid_o;
    endcase
  endfunction

  task automatic wait_sig(input int s, input string name, output int waited);
    waited = 0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clock);
      if (sig(s)) begin
        waited = k;
        return;
      end
    end
    abort(name);
  endtask

  function automatic bit calc_err(input logic [26:0] addr, input int len, input logic [1:0] burst);
    int idx;
    idx = int'(addr[11:2]);
    return (burst != 2'b01) || (addr[26:12] != 15'd0) || (idx + len > DEPTH - 1);
  endfunction

  function automatic logic [31:0] bytemask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  function automatic logic rpat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Monitor: pops the scoreboard on every B/R handshake, checks R stability on stalls.
  logic        stall_v = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  logic [3:0]  stall_id;

  always @(negedge clock) begin
    if (reset) begin
      stall_v = 1'b0;
    end else begin
      if (bvalid_o && bready_i) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          b_exp_t e;
          e = bq.pop_front();
          chk("b_id", bid_o, e.id);
          chk("b_resp", bresp_o, e.resp);
        end
      end
      if (stall_v) begin
        chk("r_stall_valid", rvalid_o, 1);
        chk("r_stall_data", rdata_o, stall_data);
        chk("r_stall_last", rlast_o, stall_last);
        chk("r_stall_id", rid_o, stall_id);
      end
      stall_v    = rvalid_o && !rready_i;
      stall_data = rdata_o;
      stall_last = rlast_o;
      stall_id   = rid_o;
      if (rvalid_o && rready_i) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          r_exp_t e;
          e = rq.pop_front();
          chk("r_id", rid_o, e.id);
          chk("r_resp", rresp_o, e.resp);
          chk("r_last", rlast_o, e.last);
          chk("r_data", rdata_o & e.mask, e.data & e.mask);
        end
      end
    end
  end

  task automatic write_txn(input logic [26:0] addr, input int len, input int id,
                           input logic [1:0] burst, input int early);
    int nb, idx, w;
    bit err;
    err = calc_err(addr, len, burst);
    idx = int'(addr[11:2]);
    nb  = (early >= 0) ? early + 1 : len + 1;
    if (!err) begin
      for (int i = 0; i < nb; i++)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) begin
            model_mem[idx+i][b*8 +: 8] = wd[i][b*8 +: 8];
            model_known[idx+i][b] = 1'b1;
          end
    end
    bq.push_back('{id: 4'(id), resp: (err || early >= 0) ? 2'b10 : 2'b00});
    awvalid_i = 1'b1; awaddr_i = addr; awlen_i = 8'(len); awid_i = 4'(id); awburst_i = burst;
    wait_sig(0, "aw_grant", w);
    aw_waited = w; aw_snap_ar = arready_o; aw_snap_w = wready_o;
    @(posedge clock); #1;
    awvalid_i = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wvalid_i = 1'b1; wdata_i = wd[i]; wstrb_i = ws[i]; wlast_i = (i == nb - 1);
      wait_sig(2, "w_beat", w);
      if (i == 0) chk("wready_t1", w, 1);
      @(posedge clock); #1;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    @(negedge clock);
    chk("bvalid_t1", bvalid_o, 1);
    chk("wready_off", wready_o, 0);
    @(posedge clock);
    repeat ($urandom_range(0, 2)) @(posedge clock);
    #1 bready_i = 1'b1;
    wait_sig(3, "b_wait", w);
    @(posedge clock); #1;
    bready_i = 1'b0;
  endtask

  task automatic push_reads(input logic [26:0] addr, input int len, input int id, input logic [1:0] burst);
    bit err;
    int idx;
    r_exp_t e;
    err = calc_err(addr, len, burst);
    idx = int'(addr[11:2]);
    for (int i = 0; i <= len; i++) begin
      e.id   = 4'(id);
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == len);
      e.data = err ? 32'h0 : model_mem[idx+i];
      e.mask = err ? 32'hFFFF_FFFF : bytemask(model_known[idx+i]);
      rq.push_back(e);
    end
  endtask

  task automatic read_txn(input logic [26:0] addr, input int len, input int id,
                          input logic [1:0] burst, input int mode);
    int w, beats, cyc;
    bit done;
    push_reads(addr, len, id, burst);
    arvalid_i = 1'b1; araddr_i = addr; arlen_i = 8'(len); arid_i = 4'(id); arburst_i = burst;
    wait_sig(1, "ar_grant", w);
    ar_waited = w; ar_snap_aw = awready_o;
    @(posedge clock); #1;
    arvalid_i = 1'b0;
    rready_i  = rpat(mode, 0);
    @(negedge clock);
    chk("rvalid_t1", rvalid_o, 1);
    beats = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      if (rvalid_o && rready_i) begin
        beats++;
        if (beats == len + 1) done = 1'b1;
      end
      @(posedge clock); #1;
      cyc++;
      rready_i = done ? 1'b0 : rpat(mode, cyc);
      if (cyc > 3000) abort("r_beats");
      if (!done) @(negedge clock);
    end
    if (mode == 0) chk("r_throughput", cyc, len + 1);
  endtask

  initial begin
    #3_000_000;
    abort("watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_known[i] = 4'h0;
    // Both address channels and W are pending while reset is held.
    reset = 1'b1;
    awvalid_i = 1'b1; awaddr_i = 27'h10; awlen_i = 8'd0; awid_i = 4'd3; awburst_i = 2'b01;
    arvalid_i = 1'b1; araddr_i = 27'h10; arlen_i = 8'd0; arid_i = 4'd6; arburst_i = 2'b01;
    wvalid_i = 1'b1; wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF; wlast_i = 1'b1;
    bready_i = 1'b0; rready_i = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_readies", {awready_o, arready_o, wready_o}, 0);
    chk("rst_b", {bvalid_o, bid_o, bresp_o}, 0);
    chk("rst_r", {rvalid_o, rlast_o, rid_o, rresp_o}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single-beat write wins the first tie; then read, then write.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_txn(27'h10, 0, 3, 2'b01, -1);
    chk("arb1_aw_wait", aw_waited, 1);
    chk("arb1_ar_blocked", aw_snap_ar, 0);
    chk("arb1_wready_pre", aw_snap_w, 0);
    awvalid_i = 1'b1; awaddr_i = 27'h200; awlen_i = 8'd0; awid_i = 4'd5; awburst_i = 2'b01;
    read_txn(27'h10, 0, 6, 2'b01, 0);
    chk("arb2_ar_wait", ar_waited, 1);
    chk("arb2_aw_blocked", ar_snap_aw, 0);
    wd[0] = $urandom; ws[0] = 4'hF;
    write_txn(27'h200, 0, 5, 2'b01, -1);
    chk("arb3_aw_wait", aw_waited, 1);

    // 16-beat incrementing burst, read back with rready toggling.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h1000_0000 + i; ws[i] = 4'hF; end
    write_txn(27'h100, 15, 1, 2'b01, -1);
    read_txn(27'h100, 15, 2, 2'b01, 1);

    // Partial strobe merge.
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    write_txn(27'h300, 0, 7, 2'b01, -1);
    wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
    write_txn(27'h300, 0, 7, 2'b01, -1);
    read_txn(27'h300, 0, 8, 2'b01, 0);

    // Range error must leave the top of RAM untouched.
    wd[0] = 32'hA5A5_0001; wd[1] = 32'hA5A5_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    write_txn(27'((DEPTH - 2) << 2), 1, 9, 2'b01, -1);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_txn(27'((DEPTH - 2) << 2), 3, 10, 2'b01, -1);
    read_txn(27'((DEPTH - 2) << 2), 1, 11, 2'b01, 0);
    read_txn(27'h40, 1, 12, 2'b10, 0);
    read_txn(27'h1000, 0, 13, 2'b01, 0);

    // Early wlast on beat 2 of an 8-beat burst.
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE_0000 + i; ws[i] = 4'hF; end
    write_txn(27'h400, 7, 4, 2'b01, -1);
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hBEEF_0000 + i; ws[i] = 4'hF; end
    write_txn(27'h400, 7, 4, 2'b01, 2);
    read_txn(27'h400, 7, 14, 2'b01, 2);

    // Reset in the middle of a read burst.
    push_reads(27'h400, 7, 15, 2'b01);
    arvalid_i = 1'b1; araddr_i = 27'h400; arlen_i = 8'd7; arid_i = 4'd15; arburst_i = 2'b01;
    wait_sig(1, "ar_grant_rst", ar_waited);
    @(posedge clock); #1;
    arvalid_i = 1'b0; rready_i = 1'b1;
    repeat (3) @(posedge clock);
    #1 rready_i = 1'b0; reset = 1'b1;
    rq.delete();
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_rvalid", rvalid_o, 0);
    chk("rst_mid_readies", {awready_o, arready_o, wready_o, bvalid_o}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    read_txn(27'h10, 0, 1, 2'b01, 0);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      int len, id, early;
      logic [26:0] addr;
      logic [1:0] burst;
      len   = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
      addr  = {15'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) addr[12 + $urandom_range(0, 14)] = 1'b1;
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'b01;
      id    = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        early = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
        write_txn(addr, len, id, burst, early);
      end else begin
        read_txn(addr, len, id, burst, $urandom_range(0, 2));
      end
    end

    repeat (3) @(posedge clock);
    chk("b_queue_drained", bq.size(), 0);
    chk("r_queue_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
